// File: rtl/msk_hpc3_feed.sv
`default_nettype none
// ============================================================================
// Module  : msk_hpc3_feed
// Brief   : Operand/randomness feeder for the swapped-input HPC3 masked AND
//           gadget, with a seeded xorshift64 PRNG and pipeline-valid tracking.
// Revision: 1.0 - initial release
// ============================================================================
module msk_hpc3_feed #(
  parameter int D             = 2,
  parameter int RND_W         = D * (D - 1),
  parameter int WARMUP_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_valid,
  input  logic [63:0]      seed,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [D-1:0]     ina_in,
  input  logic [D-1:0]     inb_in,
  output logic [D-1:0]     ina_o,
  output logic [D-1:0]     inb_o,
  output logic [D-1:0]     inb_prev_o,
  output logic [RND_W-1:0] rnd_o,
  output logic             g_in_valid,
  output logic             g_out_valid
);

  localparam int                 c_cnt_w = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WARMUP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_UNSEEDED = 2'd0,
    S_WARMUP   = 2'd1,
    S_RUN      = 2'd2
  } state_t;

  state_t             r_state;
  logic [63:0]        r_x;
  logic [c_cnt_w-1:0] r_cnt;
  logic [D-1:0]       r_ina;
  logic [D-1:0]       r_inb;
  logic [D-1:0]       r_inb_prev;
  logic [RND_W-1:0]   r_rnd;
  logic               r_g_in_valid;
  logic               r_g_out_valid;

  logic [63:0]        w_x_next;
  logic               w_accept;

  function automatic logic [63:0] xorshift64(input logic [63:0] x);
    logic [63:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 7);
    t = t ^ (t << 17);
    return t;
  endfunction

  assign w_x_next = xorshift64(r_x);
  assign in_ready = (r_state == S_RUN) && !seed_valid;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_UNSEEDED;
      r_x           <= 64'd0;
      r_cnt         <= '0;
      r_ina         <= '0;
      r_inb         <= '0;
      r_inb_prev    <= '0;
      r_rnd         <= '0;
      r_g_in_valid  <= 1'b0;
      r_g_out_valid <= 1'b0;
    end else begin
      // Pipeline stages drain regardless of reseeding.
      r_inb_prev    <= r_inb;
      r_g_out_valid <= r_g_in_valid;
      r_g_in_valid  <= 1'b0;

      if (seed_valid) begin
        r_x     <= (seed == 64'd0) ? 64'd1 : seed;
        r_cnt   <= '0;
        r_state <= S_WARMUP;
      end else begin
        case (r_state)
          S_UNSEEDED: ;
          S_WARMUP: begin
            r_x <= w_x_next;
            if (r_cnt == c_last) begin
              r_state <= S_RUN;
            end else begin
              r_cnt <= r_cnt + c_cnt_w'(1);
            end
          end
          S_RUN: begin
            if (w_accept) begin
              r_x          <= w_x_next;
              r_rnd        <= w_x_next[RND_W-1:0];
              r_ina        <= ina_in;
              r_inb        <= inb_in;
              r_g_in_valid <= 1'b1;
            end
          end
          default: r_state <= S_UNSEEDED;
        endcase
      end
    end
  end

  assign ina_o       = r_ina;
  assign inb_o       = r_inb;
  assign inb_prev_o  = r_inb_prev;
  assign rnd_o       = r_rnd;
  assign g_in_valid  = r_g_in_valid;
  assign g_out_valid = r_g_out_valid;

endmodule
`default_nettype wire
